// File: rtl/seq_onehot_decoder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_dec_pkg                                                     |
// | Brief    : Mode encoding and one-hot helper for the sequential decoder.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package seq_dec_pkg;

   localparam int c_MAX_SEL_WIDTH = 8;
   localparam int c_MAX_OUT_WIDTH = 1 << c_MAX_SEL_WIDTH;

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'b00,
      MODE_PULSE = 2'b01,
      MODE_SCAN  = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   // Decodes at the widest supported select; callers keep the low OUT_WIDTH bits.
   function automatic logic [c_MAX_OUT_WIDTH-1:0] onehot_f(input logic [c_MAX_SEL_WIDTH-1:0] sel);
      logic [c_MAX_OUT_WIDTH-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_onehot_decoder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_dec_if                                                      |
// | Brief    : Select/enable/mode request bundle and decoded result bundle.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface seq_dec_if
   import seq_dec_pkg::*;
#(
   parameter int SEL_WIDTH = 2
) ();

   localparam int OUT_WIDTH = 1 << SEL_WIDTH;

   logic [SEL_WIDTH-1:0] sel;
   logic                 en;
   mode_e                mode;
   logic [OUT_WIDTH-1:0] dec_out;
   logic [SEL_WIDTH-1:0] idx;
   logic                 active;
   logic                 mode_err;

   modport master (
      output sel, en, mode,
      input  dec_out, idx, active, mode_err
   );

   modport slave (
      input  sel, en, mode,
      output dec_out, idx, active, mode_err
   );

endinterface
`default_nettype wire

// File: rtl/seq_onehot_decoder_dec_onehot.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dec_onehot                                                      |
// | Brief    : Combinational SEL_WIDTH-to-2^SEL_WIDTH one-hot decoder w/ enable|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dec_onehot
   import seq_dec_pkg::*;
#(
   parameter int SEL_WIDTH = 2
) (
   input  logic [SEL_WIDTH-1:0]         i_sel,
   input  logic                         i_en,
   output logic [(1 << SEL_WIDTH)-1:0]  o_dec
);

   localparam int OUT_WIDTH = 1 << SEL_WIDTH;

   logic [c_MAX_SEL_WIDTH-1:0] w_sel_ext;
   logic [c_MAX_OUT_WIDTH-1:0] w_full;

   assign w_sel_ext = c_MAX_SEL_WIDTH'(i_sel);
   assign w_full    = onehot_f(w_sel_ext);
   assign o_dec     = i_en ? w_full[OUT_WIDTH-1:0] : '0;

   // Bits above OUT_WIDTH are always zero for an in-range select.
   generate
      if (OUT_WIDTH < c_MAX_OUT_WIDTH) begin : g_hi_bits
         logic w_unused_hi;
         assign w_unused_hi = |w_full[c_MAX_OUT_WIDTH-1:OUT_WIDTH];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/seq_onehot_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_onehot_decoder                                              |
// | Brief    : Registered one-hot decoder with LEVEL, PULSE and SCAN modes.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_onehot_decoder
   import seq_dec_pkg::*;
#(
   parameter int SEL_WIDTH  = 2,
   parameter int SCAN_DWELL = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   seq_dec_if.slave bus
);

   localparam int OUT_WIDTH = 1 << SEL_WIDTH;
   localparam int c_DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
   localparam logic [c_DWELL_W-1:0] c_DWELL_LAST = c_DWELL_W'(SCAN_DWELL - 1);

   logic                 r_en_q;
   logic [SEL_WIDTH-1:0] r_scan_idx;
   logic [c_DWELL_W-1:0] r_dwell;
   logic [OUT_WIDTH-1:0] r_dec_out;
   logic [SEL_WIDTH-1:0] r_idx;
   logic                 r_active;
   logic                 r_mode_err;

   logic [SEL_WIDTH-1:0] w_dec_sel;
   logic                 w_dec_en;
   logic [OUT_WIDTH-1:0] w_dec;
   logic                 w_scan_run;

   // One decoder serves every mode; only its select and enable are muxed.
   always_comb begin
      w_dec_sel = bus.sel;
      w_dec_en  = 1'b0;
      case (bus.mode)
         MODE_LEVEL: w_dec_en = bus.en;
         MODE_PULSE: w_dec_en = bus.en & ~r_en_q;
         MODE_SCAN: begin
            w_dec_sel = r_scan_idx;
            w_dec_en  = bus.en;
         end
         default:    w_dec_en = 1'b0;
      endcase
   end

   assign w_scan_run = (bus.mode == MODE_SCAN) && bus.en;

   dec_onehot #(
      .SEL_WIDTH (SEL_WIDTH)
   ) u_dec (
      .i_sel (w_dec_sel),
      .i_en  (w_dec_en),
      .o_dec (w_dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_q     <= 1'b0;
         r_scan_idx <= '0;
         r_dwell    <= '0;
         r_dec_out  <= '0;
         r_idx      <= '0;
         r_active   <= 1'b0;
         r_mode_err <= 1'b0;
      end else begin
         r_en_q     <= bus.en;
         r_dec_out  <= w_dec;
         r_idx      <= w_dec_en ? w_dec_sel : '0;
         r_active   <= w_dec_en;
         r_mode_err <= (bus.mode == MODE_RSVD);
         // Counters only advance while sweeping, so any other cycle restarts the sweep at 0.
         if (w_scan_run) begin
            if (r_dwell == c_DWELL_LAST) begin
               r_dwell    <= '0;
               r_scan_idx <= r_scan_idx + 1'b1;
            end else begin
               r_dwell    <= r_dwell + 1'b1;
            end
         end else begin
            r_dwell    <= '0;
            r_scan_idx <= '0;
         end
      end
   end

   assign bus.dec_out  = r_dec_out;
   assign bus.idx      = r_idx;
   assign bus.active   = r_active;
   assign bus.mode_err = r_mode_err;

endmodule
`default_nettype wire
